cpu_bus_fabric: RTL and testbench

- Parametrised 6502-side address decoder and bus fabric for the QOI platform, between the 65C02 core and its N memory/peripheral regions (RAM, IMG, QOI, accelerator memory, accelerator registers, ROM).
- Decodes per-region chip selects and returns read data one cycle after the address phase.
- Inserts per-region wait states by driving the CPU RDY input low.
- Flags unmapped accesses and writes to read-only regions with a sticky error.
- Detects the end-of-program halt (address bus held at all-ones).

---
 rtl/cpu_bus_fabric.sv | 201 ++++++++++++++++++++
 tb/tb_cpu_bus_fabric.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_fabric.sv
// 65C02-side address decoder and bus fabric: priority region decode, per-region
// wait states via RDY, one-cycle read return, sticky bus error and halt detect.
module cpu_bus_fabric #(
    parameter int N_REGIONS = 6,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter logic [N_REGIONS*ADDR_W-1:0] REGION_BASE =
        {16'hC000, 16'hA400, 16'hA000, 16'h9000, 16'h8000, 16'h0000},
    parameter logic [N_REGIONS*5-1:0] REGION_SIZE_LOG2 =
        {5'd14, 5'd3, 5'd10, 5'd12, 5'd12, 5'd15},
    parameter logic [N_REGIONS*4-1:0] REGION_WAIT = '0,
    parameter logic [N_REGIONS-1:0] REGION_RO = 6'b100000,
    parameter logic [DATA_W-1:0] UNMAPPED_VALUE = 8'hFF,
    parameter int HALT_CYCLES = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [ADDR_W-1:0]           addr,
    input  logic                        we,
    output logic [DATA_W-1:0]           cpu_di,
    output logic                        cpu_rdy,
    output logic [N_REGIONS-1:0]        region_cs,
    output logic [N_REGIONS-1:0]        region_we,
    input  logic [N_REGIONS*DATA_W-1:0] region_rdata,
    input  logic                        err_clr,
    output logic                        bus_err,
    output logic [ADDR_W-1:0]           err_addr,
    output logic                        halted
);
    localparam int SEL_W  = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;
    localparam int HALT_W = $clog2(HALT_CYCLES + 1);

    typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

    state_t             state_r, state_n;
    logic [3:0]         cnt_r, cnt_n;
    logic [SEL_W-1:0]   hold_sel_r, hold_sel_n;
    logic [SEL_W-1:0]   sel_s, eff_sel_s, sel_q_r;
    logic               hit_s, eff_hit_s, valid_q_r;
    logic [3:0]         wait_s;
    logic               rdy_s, done_s, err_now_s;
    logic [N_REGIONS-1:0] cs_s, we_s;
    logic               bus_err_r, halted_r;
    logic [ADDR_W-1:0]  err_addr_r;
    logic [HALT_W-1:0]  halt_cnt_r, halt_cnt_n;

    // Priority decode: scanning downward leaves the lowest matching index.
    always_comb begin
        hit_s = 1'b0;
        sel_s = '0;
        for (int i = N_REGIONS - 1; i >= 0; i--) begin
            if ((addr >> REGION_SIZE_LOG2[i*5 +: 5]) ==
                (REGION_BASE[i*ADDR_W +: ADDR_W] >> REGION_SIZE_LOG2[i*5 +: 5])) begin
                hit_s = 1'b1;
                sel_s = SEL_W'(i);
            end else begin
                sel_s = sel_s;
            end
        end
        wait_s = REGION_WAIT[int'(sel_s)*4 +: 4];
    end

    // Wait-state FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 4'd0;
            hold_sel_r <= '0;
        end else begin
            state_r    <= state_n;
            cnt_r      <= cnt_n;
            hold_sel_r <= hold_sel_n;
        end
    end

    // Wait-state FSM next-state logic; the region is latched on entry to WAIT.
    always_comb begin
        state_n    = state_r;
        cnt_n      = cnt_r;
        hold_sel_n = hold_sel_r;
        case (state_r)
            ST_IDLE: begin
                if (hit_s && (wait_s != 4'd0)) begin
                    state_n    = ST_WAIT;
                    cnt_n      = wait_s - 4'd1;
                    hold_sel_n = sel_s;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r != 4'd0) begin
                    cnt_n = cnt_r - 4'd1;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Wait-state FSM outputs: RDY, chip selects, write strobes, error event.
    always_comb begin
        if (state_r == ST_WAIT) begin
            eff_sel_s = hold_sel_r;
            eff_hit_s = 1'b1;
            rdy_s     = (cnt_r == 4'd0);
        end else begin
            eff_sel_s = sel_s;
            eff_hit_s = hit_s;
            rdy_s     = !(hit_s && (wait_s != 4'd0));
        end
        if (reset) begin
            rdy_s = 1'b1;
        end else begin
            rdy_s = rdy_s;
        end
        done_s = rdy_s && !reset;
        cs_s   = '0;
        we_s   = '0;
        if (eff_hit_s && !reset) begin
            cs_s[eff_sel_s] = 1'b1;
        end else begin
            cs_s = '0;
        end
        if (we && done_s && eff_hit_s && !REGION_RO[eff_sel_s]) begin
            we_s[eff_sel_s] = 1'b1;
        end else begin
            we_s = '0;
        end
        err_now_s = done_s && (!eff_hit_s || (we && REGION_RO[eff_sel_s]));
    end

    // Read-return pipeline; captured only when the access completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q_r   <= '0;
            valid_q_r <= 1'b0;
        end else if (done_s) begin
            sel_q_r   <= eff_sel_s;
            valid_q_r <= eff_hit_s;
        end else begin
            sel_q_r   <= sel_q_r;
            valid_q_r <= valid_q_r;
        end
    end

    // Sticky error: keep the first address, but a new error in a clear cycle reloads it.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_err_r  <= 1'b0;
            err_addr_r <= '0;
        end else if (err_now_s) begin
            bus_err_r <= 1'b1;
            if (!bus_err_r || err_clr) begin
                err_addr_r <= addr;
            end else begin
                err_addr_r <= err_addr_r;
            end
        end else if (err_clr) begin
            bus_err_r  <= 1'b0;
            err_addr_r <= '0;
        end else begin
            bus_err_r  <= bus_err_r;
            err_addr_r <= err_addr_r;
        end
    end

    // Saturating count of consecutive all-ones address cycles.
    always_comb begin
        if (&addr) begin
            if (halt_cnt_r != HALT_W'(HALT_CYCLES)) begin
                halt_cnt_n = halt_cnt_r + HALT_W'(1);
            end else begin
                halt_cnt_n = halt_cnt_r;
            end
        end else begin
            halt_cnt_n = '0;
        end
    end

    // Halt counter and sticky halt flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            halt_cnt_r <= '0;
            halted_r   <= 1'b0;
        end else begin
            halt_cnt_r <= halt_cnt_n;
            halted_r   <= halted_r || (halt_cnt_n == HALT_W'(HALT_CYCLES));
        end
    end

    assign cpu_rdy   = rdy_s;
    assign region_cs = cs_s;
    assign region_we = we_s;
    assign cpu_di    = valid_q_r ? region_rdata[int'(sel_q_r)*DATA_W +: DATA_W] : UNMAPPED_VALUE;
    assign bus_err   = bus_err_r;
    assign err_addr  = err_addr_r;
    assign halted    = halted_r;

endmodule

// File: tb/tb_cpu_bus_fabric.sv
// Scoreboard bench for cpu_bus_fabric on the default QOI memory map (ACC region with 2 waits).
module tb_cpu_bus_fabric;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addr;
    logic        we;
    logic [7:0]  cpu_di;
    logic        cpu_rdy;
    logic [5:0]  region_cs;
    logic [5:0]  region_we;
    logic [47:0] region_rdata;
    logic        err_clr;
    logic        bus_err;
    logic [15:0] err_addr;
    logic        halted;

    always #5 clk = ~clk;

    cpu_bus_fabric #(
        .REGION_WAIT(24'h002000)
    ) dut (
        .clk(clk), .reset(reset), .addr(addr), .we(we), .cpu_di(cpu_di),
        .cpu_rdy(cpu_rdy), .region_cs(region_cs), .region_we(region_we),
        .region_rdata(region_rdata), .err_clr(err_clr), .bus_err(bus_err),
        .err_addr(err_addr), .halted(halted)
    );

    // Independent model of the map as byte ranges.
    int base_m[6] = '{32'h0000, 32'h8000, 32'h9000, 32'hA000, 32'hA400, 32'hC000};
    int size_m[6] = '{32768, 4096, 4096, 1024, 8, 16384};
    int wait_m[6] = '{0, 0, 0, 2, 0, 0};
    bit ro_m[6]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    int          total = 0;
    int          bad = 0;
    logic [7:0]  exp_q[$];
    bit          exp_err = 1'b0;
    logic [15:0] exp_eaddr = 16'h0000;
    int          halt_m = 0;
    bit          exp_halt = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_sel(input logic [15:0] a);
        for (int i = 0; i < 6; i++) begin
            if (int'(a) >= base_m[i] && int'(a) < base_m[i] + size_m[i]) return i;
        end
        return -1;
    endfunction

    task automatic access(input logic [15:0] a, input logic w, input logic clr);
        int s;
        int wt;
        logic [5:0] cs_e;
        bit err_e;
        s    = model_sel(a);
        wt   = (s >= 0) ? wait_m[s] : 0;
        cs_e = (s >= 0) ? 6'(1 << s) : 6'd0;
        for (int k = 0; k < 6; k++) region_rdata[k*8 +: 8] = 8'($urandom);
        addr = a;
        we = w;
        err_clr = clr;
        for (int c = 0; c <= wt; c++) begin
            @(negedge clk);
            check_val("rdy", cpu_rdy, 32'(c == wt));
            check_val("cs", region_cs, cs_e);
            check_val("strobe", region_we, (w && c == wt && s >= 0 && !ro_m[s]) ? cs_e : 6'd0);
            if (c == wt && !w) exp_q.push_back((s >= 0) ? region_rdata[s*8 +: 8] : 8'hFF);
            @(posedge clk);
            #1;
            err_clr = 1'b0;
            if (a == 16'hFFFF) begin
                if (halt_m < 5) halt_m++;
            end else begin
                halt_m = 0;
            end
            if (halt_m == 5) exp_halt = 1'b1;
            check_val("halted", halted, exp_halt);
        end
        err_e = (s < 0) || (w && ro_m[s]);
        if (err_e) begin
            if (!exp_err || clr) exp_eaddr = a;
            exp_err = 1'b1;
        end else if (clr) begin
            exp_err = 1'b0;
            exp_eaddr = 16'h0000;
        end
        check_val("bus_err", bus_err, exp_err);
        check_val("err_addr", err_addr, exp_eaddr);
        if (exp_q.size() > 0) check_val("cpu_di", cpu_di, exp_q.pop_front());
    endtask

    logic [15:0] halt_seq[10] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFE,
                                  16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};

    initial begin
        reset = 1'b1;
        addr = 16'h8123;
        we = 1'b1;
        err_clr = 1'b0;
        region_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_rdy", cpu_rdy, 1'b1);
        check_val("rst_cs", region_cs, 6'd0);
        check_val("rst_strobe", region_we, 6'd0);
        check_val("rst_err", bus_err, 1'b0);
        check_val("rst_eaddr", err_addr, 16'h0000);
        check_val("rst_halt", halted, 1'b0);
        check_val("rst_di", cpu_di, 8'hFF);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_val("post_rst_di", cpu_di, 8'hFF);

        // Reads across every region, including boundaries and a waited read.
        access(16'h8123, 1'b0, 1'b0);
        access(16'h0042, 1'b0, 1'b0);
        access(16'h7FFF, 1'b0, 1'b0);
        access(16'h9ABC, 1'b0, 1'b0);
        access(16'hA3FF, 1'b0, 1'b0);
        access(16'hA404, 1'b0, 1'b0);
        access(16'hC100, 1'b0, 1'b0);
        // Writes: waited, zero-wait, and to read-only ROM.
        access(16'hA010, 1'b1, 1'b0);
        access(16'h8000, 1'b1, 1'b0);
        access(16'h0001, 1'b1, 1'b0);
        access(16'hC000, 1'b1, 1'b0);
        // Clear, then first-error retention and clear-vs-new-error.
        access(16'h0000, 1'b0, 1'b1);
        access(16'hA408, 1'b0, 1'b0);
        access(16'hA40A, 1'b1, 1'b0);
        access(16'hA500, 1'b0, 1'b1);
        // Halt detection with an interrupted run.
        for (int i = 0; i < 10; i++) access(halt_seq[i], 1'b0, 1'b0);

        // Reset in the middle of a waited write.
        addr = 16'hA010;
        we = 1'b1;
        @(negedge clk);
        check_val("mw_rdy", cpu_rdy, 1'b0);
        check_val("mw_cs", region_cs, 6'b001000);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check_val("mwr_rdy", cpu_rdy, 1'b1);
        check_val("mwr_cs", region_cs, 6'd0);
        check_val("mwr_strobe", region_we, 6'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_err = 1'b0;
        exp_eaddr = 16'h0000;
        exp_q.delete();
        halt_m = 0;
        exp_halt = 1'b0;
        check_val("mwr_err", bus_err, 1'b0);
        check_val("mwr_halt", halted, 1'b0);
        check_val("mwr_di", cpu_di, 8'hFF);
        access(16'hA010, 1'b1, 1'b0);
        access(16'h8456, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
